// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, compare selects, instruction field positions
//               and issue FSM states for the ALU issue front end.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int REG_IDX_W = 4;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_EPAR   = 4'b0101;

  localparam logic [2:0] LTGT_EQ = 3'd0;
  localparam logic [2:0] LTGT_LE = 3'd1;
  localparam logic [2:0] LTGT_GE = 3'd2;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int EQ_BIT   = 11;
  localparam int LTGT_MSB = 10;
  localparam int LTGT_LSB = 8;
  localparam int RS_MSB   = 7;
  localparam int RS_LSB   = 4;
  localparam int RT_MSB   = 3;
  localparam int RT_LSB   = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_READ_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Splits an instruction word into ALU control fields and
//               classifies the opcode as write-back, branch or illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
  import alu_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  op,
  output logic        eq,
  output logic [2:0]  ltgt,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic        is_wb,
  output logic        is_br,
  output logic        is_ill
);

  assign op   = instr[OP_MSB:OP_LSB];
  assign eq   = instr[EQ_BIT];
  assign ltgt = instr[LTGT_MSB:LTGT_LSB];
  assign rs   = instr[RS_MSB:RS_LSB];
  assign rt   = instr[RT_MSB:RT_LSB];

  // Only add/sub (shared opcode, eq selects) and parity write a register.
  assign is_wb  = (op == OP_ADD) || (op == OP_EPAR);
  assign is_br  = (op == OP_BRANCH);
  assign is_ill = !(is_wb || is_br);

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Five-state issue sequencer: accept instruction, read rs and
//               rt, drive the external ALU, then write back or resolve branch.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [15:0]        instr,
  output logic               instr_ready,
  output logic [RADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [3:0]         alu_op,
  output logic               alu_eq,
  output logic [2:0]         alu_ltgt,
  output logic [DATA_W-1:0]  alu_res,
  output logic [DATA_W-1:0]  alu_register,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_compres,
  output logic               br_valid,
  output logic               br_taken,
  output logic               illegal,
  output logic               done
);

  state_t r_state;
  state_t w_next;

  logic [3:0]           w_op;
  logic                 w_eq;
  logic [2:0]           w_ltgt;
  logic [REG_IDX_W-1:0] w_rs;
  logic [REG_IDX_W-1:0] w_rt;
  logic                 w_is_wb;
  logic                 w_is_br;
  logic                 w_is_ill;
  logic                 w_accept;

  logic [3:0]           r_op;
  logic                 r_eq;
  logic [2:0]           r_ltgt;
  logic [REG_IDX_W-1:0] r_rs;
  logic [REG_IDX_W-1:0] r_rt;
  logic                 r_is_wb;
  logic                 r_is_br;
  logic                 r_is_ill;
  logic [DATA_W-1:0]    r_opa;
  logic [DATA_W-1:0]    r_result;
  logic                 r_compres;

  logic [3:0]           r_alu_op;
  logic                 r_alu_eq;
  logic [2:0]           r_alu_ltgt;
  logic [DATA_W-1:0]    r_alu_res;
  logic [DATA_W-1:0]    r_alu_register;

  instr_decode u_decode (
    .instr  (instr),
    .op     (w_op),
    .eq     (w_eq),
    .ltgt   (w_ltgt),
    .rs     (w_rs),
    .rt     (w_rt),
    .is_wb  (w_is_wb),
    .is_br  (w_is_br),
    .is_ill (w_is_ill)
  );

  assign w_accept = instr_valid && (r_state == S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op           <= '0;
      r_eq           <= 1'b0;
      r_ltgt         <= '0;
      r_rs           <= '0;
      r_rt           <= '0;
      r_is_wb        <= 1'b0;
      r_is_br        <= 1'b0;
      r_is_ill       <= 1'b0;
      r_opa          <= '0;
      r_result       <= '0;
      r_compres      <= 1'b0;
      r_alu_op       <= '0;
      r_alu_eq       <= 1'b0;
      r_alu_ltgt     <= '0;
      r_alu_res      <= '0;
      r_alu_register <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op     <= w_op;
        r_eq     <= w_eq;
        r_ltgt   <= w_ltgt;
        r_rs     <= w_rs;
        r_rt     <= w_rt;
        r_is_wb  <= w_is_wb;
        r_is_br  <= w_is_br;
        r_is_ill <= w_is_ill;
      end
      if (r_state == S_READ_A) begin
        r_opa <= rf_rdata;
      end
      // ALU inputs are loaded as a group so they are stable for all of EXEC
      // and keep their values afterwards until the next instruction's EXEC.
      if (r_state == S_READ_B) begin
        r_alu_res      <= r_opa;
        r_alu_register <= rf_rdata;
        r_alu_op       <= r_op;
        r_alu_eq       <= r_eq;
        r_alu_ltgt     <= r_ltgt;
      end
      if (r_state == S_EXEC) begin
        r_result  <= alu_out;
        r_compres <= alu_compres;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    rf_raddr    = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    br_valid    = 1'b0;
    br_taken    = 1'b0;
    illegal     = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = S_READ_A;
      end
      S_READ_A: begin
        rf_raddr = RADDR_W'(r_rs);
        w_next   = S_READ_B;
      end
      S_READ_B: begin
        rf_raddr = RADDR_W'(r_rt);
        w_next   = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_WB;
      end
      S_WB: begin
        done = 1'b1;
        if (r_is_wb) begin
          rf_we    = 1'b1;
          rf_waddr = RADDR_W'(r_rs);
          rf_wdata = r_result;
        end
        if (r_is_br) begin
          br_valid = 1'b1;
          br_taken = r_compres;
        end
        illegal = r_is_ill;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign alu_op       = r_alu_op;
  assign alu_eq       = r_alu_eq;
  assign alu_ltgt     = r_alu_ltgt;
  assign alu_res      = r_alu_res;
  assign alu_register = r_alu_register;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Self-checking bench for alu_issue with register-file and ALU
//               environment models plus a per-instruction reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [3:0]  alu_op;
  logic        alu_eq;
  logic [2:0]  alu_ltgt;
  logic [15:0] alu_res;
  logic [15:0] alu_register;
  logic [15:0] alu_out;
  logic        alu_compres;
  logic        br_valid;
  logic        br_taken;
  logic        illegal;
  logic        done;

  int passed = 0;
  int total  = 0;

  alu_issue #(.DATA_W(16), .RADDR_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .rf_raddr     (rf_raddr),
    .rf_rdata     (rf_rdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .alu_op       (alu_op),
    .alu_eq       (alu_eq),
    .alu_ltgt     (alu_ltgt),
    .alu_res      (alu_res),
    .alu_register (alu_register),
    .alu_out      (alu_out),
    .alu_compres  (alu_compres),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .illegal      (illegal),
    .done         (done)
  );

  always #5 clock = ~clock;

  // Behavioural ALU: {compres, out}
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic eq,
                                         input logic [2:0] lt, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] o;
    logic        c;
    if (op == OP_ADD)       o = eq ? (a + b) : (a - b);
    else if (op == OP_EPAR) o = {15'd0, ^a};
    else                    o = a ^ b;
    case (lt)
      LTGT_EQ: c = (a == b);
      LTGT_LE: c = (a <= b);
      LTGT_GE: c = (a >= b);
      default: c = 1'b0;
    endcase
    return {c, o};
  endfunction

  always_comb {alu_compres, alu_out} = alu_fn(alu_op, alu_eq, alu_ltgt, alu_res, alu_register);

  // Environment register file, written by the DUT or by bench preload.
  logic [15:0] regs [16];
  logic [15:0] mregs[16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_a  = '0;
  logic [15:0] pre_d  = '0;

  always_comb rf_rdata = regs[rf_raddr];

  always @(posedge clock) begin
    if (pre_we)     regs[pre_a]    <= pre_d;
    else if (rf_we) regs[rf_waddr] <= rf_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    mregs[a] = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic eq, input logic [2:0] lt,
                                     input logic [3:0] rs, input logic [3:0] rt);
    return {op, eq, lt, rs, rt};
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    case ($urandom_range(0, 4))
      0:       op = OP_ADD;
      1:       op = OP_BRANCH;
      2:       op = OP_EPAR;
      3:       op = OP_SUB;
      default: op = 4'($urandom);
    endcase
    return mk(op, 1'($urandom), 3'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
  endfunction

  // Issue one instruction (called just after a negedge, DUT idle) and check
  // every cycle through retirement. want >= 0 overrides the model's value.
  task automatic run(input logic [15:0] w, input bit keep, input int want);
    logic [3:0]  op, rs, rt;
    logic [2:0]  lt;
    logic        eq, wr, br;
    logic [15:0] a, b, exp_out;
    logic [16:0] m;
    logic        exp_cmp;
    op = w[15:12]; eq = w[11]; lt = w[10:8]; rs = w[7:4]; rt = w[3:0];
    a = mregs[rs]; b = mregs[rt];
    m = alu_fn(op, eq, lt, a, b);
    exp_out = (want >= 0) ? want[15:0] : m[15:0];
    exp_cmp = (want >= 0) ? want[0]    : m[16];
    wr = (op == OP_ADD) || (op == OP_EPAR);
    br = (op == OP_BRANCH);
    instr = w; instr_valid = 1'b1;
    chk("ready_idle", instr_ready, 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (c == 1) begin
        if (!keep) instr_valid = 1'b0;
        instr = 16'($urandom);
      end
      chk("ready_busy", instr_ready, 0);
      if (c < 4) chk("no_early_pulse", {done, rf_we, br_valid, illegal}, 0);
      case (c)
        1: chk("raddr_rs", rf_raddr, rs);
        2: chk("raddr_rt", rf_raddr, rt);
        3: begin
          chk("raddr_exec", rf_raddr, 0);
          chk("alu_res", alu_res, a);
          chk("alu_register", alu_register, b);
          chk("alu_ctl", {alu_op, alu_eq, alu_ltgt}, {op, eq, lt});
        end
        default: begin
          chk("done", done, 1);
          chk("alu_ctl_hold", {alu_op, alu_eq, alu_ltgt}, {op, eq, lt});
          chk("rf_we", rf_we, wr);
          chk("br_valid", br_valid, br);
          chk("illegal", illegal, !wr && !br);
          if (wr) begin
            chk("rf_waddr", rf_waddr, rs);
            chk("rf_wdata", rf_wdata, exp_out);
            mregs[rs] = exp_out;
          end
          if (br) chk("br_taken", br_taken, exp_cmp);
        end
      endcase
    end
    @(negedge clock);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", instr_ready, 1);
    chk("rst_ctl", {rf_raddr, rf_we, rf_waddr, alu_op, alu_eq, alu_ltgt,
                    br_valid, br_taken, illegal, done}, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_alu", {alu_res, alu_register}, 0);
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    @(negedge clock);
    for (int i = 0; i < 16; i++) set_reg(4'(i), 16'($urandom));
    chk_reset_outputs();
    reset = 1'b0;
    @(negedge clock);

    // Directed cases
    set_reg(1, 16'd5); set_reg(2, 16'd3);
    run(mk(OP_ADD, 1, LTGT_EQ, 1, 2), 0, 8);
    set_reg(1, 16'd3); set_reg(2, 16'd5);
    run(mk(OP_ADD, 0, LTGT_EQ, 1, 2), 0, 16'hFFFE);
    set_reg(1, 16'hFFFF); set_reg(2, 16'd1);
    run(mk(OP_ADD, 1, LTGT_EQ, 1, 2), 0, 0);
    set_reg(3, 16'd7); set_reg(4, 16'd7);
    run(mk(OP_BRANCH, 1, LTGT_EQ, 3, 4), 0, 1);
    set_reg(4, 16'd8);
    run(mk(OP_BRANCH, 1, LTGT_EQ, 3, 4), 0, 0);
    set_reg(5, 16'h0007);
    run(mk(OP_EPAR, 0, LTGT_EQ, 5, 5), 0, 1);
    set_reg(5, 16'h0003);
    run(mk(OP_EPAR, 0, LTGT_EQ, 5, 5), 0, 0);
    run(mk(4'hF, 0, LTGT_EQ, 6, 7), 0, -1);
    // rs written by one instruction and read by the next
    run(mk(OP_ADD, 1, LTGT_EQ, 8, 9), 0, -1);
    run(mk(OP_ADD, 1, LTGT_EQ, 8, 8), 0, -1);

    // Back-to-back with instr_valid held high
    for (int i = 0; i < 8; i++) run(rand_instr(), 1, -1);
    instr_valid = 1'b0;

    // Randomised instructions
    for (int i = 0; i < 40; i++) run(rand_instr(), 0, -1);

    // Reset during EXEC abandons the instruction
    instr = mk(OP_ADD, 1, LTGT_EQ, 10, 11); instr_valid = 1'b1;
    @(negedge clock); instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("mid_exec_state", {instr_ready, rf_raddr}, 0);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_outputs();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("post_reset_quiet", {rf_we, done, br_valid, illegal}, 0);
    end
    run(rand_instr(), 0, -1);
    run(mk(OP_ADD, 0, LTGT_EQ, 10, 11), 0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
